// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module : lfsr_pkg
// Brief  : Shared types and constants for the random-byte arbiter slice.
// Rev    : 1.0
// ============================================================================
package lfsr_pkg;

  localparam int RND_W = 8;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector: first set request at/after ptr.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_src;

  // Requests at or above the pointer win; otherwise wrap to the lowest set bit.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (IW'(i) >= i_ptr);
    end
  end

  assign w_hi  = i_req & w_mask;
  assign w_src = (|w_hi) ? w_hi : i_req;
  assign o_any = |i_req;

  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        o_idx       = IW'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module : lfsr_rng_arbiter
// Brief  : Round-robin burst distribution of a free-running random byte stream.
// Rev    : 1.0
// ============================================================================
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int BURST         = 4,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RND_W-1:0] rnd_in,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  data_ready,
  output logic [NREQ-1:0]  gnt,
  output logic [RND_W-1:0] data_out,
  output logic             data_valid,
  output logic             warmup_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [7:0]    c_WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [BW-1:0] c_BEAT_LAST = BW'(BURST - 1);
  localparam logic [IW-1:0] c_PTR_LAST  = IW'(NREQ - 1);

  state_t           r_state;
  logic [7:0]       r_wcnt;
  logic [BW-1:0]    r_beat;
  logic [IW-1:0]    r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [RND_W-1:0] r_data;
  logic             r_valid;
  logic             r_wdone;

  logic [NREQ-1:0]  w_win;
  logic [IW-1:0]    w_win_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_hold;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // r_gnt is one-hot, so masking collapses to the granted requester's bit.
  assign w_accept = r_valid & (|(data_ready & r_gnt));
  assign w_hold   = |(req & r_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WARMUP;
      r_wcnt  <= '0;
      r_beat  <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wdone <= 1'b0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (r_wcnt == c_WARM_LAST) begin
            r_wdone <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_data  <= rnd_in;
            r_valid <= 1'b1;
            r_beat  <= '0;
            r_ptr   <= (w_win_idx == c_PTR_LAST) ? '0 : w_win_idx + IW'(1);
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          // A dropped request ends the burst; a beat accepted this cycle stands.
          if (!w_hold) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            if (r_beat == c_BEAT_LAST) begin
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_data <= rnd_in;
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: r_state <= ST_WARMUP;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign warmup_done = r_wdone;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_lfsr_rng_arbiter
// Brief  : Directed self-checking bench for lfsr_rng_arbiter (4 req, burst 4).
// Rev    : 1.0
// ============================================================================
module tb_lfsr_rng_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] rnd_in;
  logic [3:0] req;
  logic [3:0] data_ready;
  logic [3:0] gnt;
  logic [7:0] data_out;
  logic       data_valid;
  logic       warmup_done;

  int         checks;
  int         errors;
  logic [7:0] prev;
  logic [7:0] held;

  lfsr_rng_arbiter #(
    .NREQ          (4),
    .BURST         (4),
    .WARMUP_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rnd_in      (rnd_in),
    .req         (req),
    .data_ready  (data_ready),
    .gnt         (gnt),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .warmup_done (warmup_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The generator stand-in advances one byte per cycle, just after each edge.
  task automatic tick;
    @(posedge clk);
    #1;
    rnd_in = rnd_in + 8'd1;
  endtask

  task automatic test_reset;
    rst_n      = 1'b1;
    req        = 4'b0001;
    data_ready = 4'b1111;
    rnd_in     = 8'h10;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, data_out, data_valid, warmup_done} !== 14'b0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b data=%h valid=%b wd=%b expected all 0",
               gnt, data_out, data_valid, warmup_done);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_warmup;
    int bad;
    bad = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (warmup_done !== 1'b0 || data_valid !== 1'b0 || gnt !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL warmup_quiet: got %0d active cycles expected 0", bad);
    end
    tick();
    checks++;
    if (warmup_done !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL warmup_done_64: got wd=%b gnt=%b expected wd=1 gnt=0000", warmup_done, gnt);
    end
    prev = rnd_in;
    tick();
    checks++;
    if (gnt !== 4'b0001 || data_valid !== 1'b1 || data_out !== prev) begin
      errors++;
      $display("FAIL first_grant_65: got gnt=%b valid=%b data=%h expected 0001 1 %h",
               gnt, data_valid, data_out, prev);
    end
  endtask

  task automatic test_burst_content;
    for (int b = 1; b <= 3; b++) begin
      prev = rnd_in;
      tick();
      checks++;
      if (data_out !== prev || gnt !== 4'b0001 || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL burst_beat%0d: got data=%h gnt=%b expected data=%h gnt=0001",
                 b, data_out, gnt, prev);
      end
    end
    // Request drops on the same cycle the last beat is accepted.
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || data_valid !== 1'b0 || warmup_done !== 1'b1) begin
      errors++;
      $display("FAIL burst_end: got gnt=%b valid=%b wd=%b expected 0000 0 1",
               gnt, data_valid, warmup_done);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] exp;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << ((n + 1) % 4);
      tick();
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", n, gnt, exp);
      end
      for (int b = 0; b < 3; b++) tick();
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap%0d: got %b expected 0000", n, gnt);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_stall;
    req  = 4'b0100;
    prev = rnd_in;
    tick();
    checks++;
    if (gnt !== 4'b0100 || data_out !== prev) begin
      errors++;
      $display("FAIL stall_grant: got gnt=%b data=%h expected 0100 %h", gnt, data_out, prev);
    end
    prev = rnd_in;
    tick();
    held = prev;
    // Only the granted requester's ready matters; the others stay high.
    data_ready = 4'b1011;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (data_out !== held || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got data=%h valid=%b expected %h 1",
                 s, data_out, data_valid, held);
      end
    end
    data_ready = 4'b1111;
    prev = rnd_in;
    tick();
    checks++;
    if (data_out !== prev) begin
      errors++;
      $display("FAIL stall_resume: got %h expected %h", data_out, prev);
    end
    prev = rnd_in;
    tick();
    checks++;
    if (data_out !== prev || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL stall_beat3: got data=%h gnt=%b expected %h 0100", data_out, gnt, prev);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got gnt=%b valid=%b expected 0000 0", gnt, data_valid);
    end
  endtask

  task automatic test_abort;
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL abort_grant: got %b expected 0010", gnt);
    end
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got gnt=%b valid=%b expected 0000 0", gnt, data_valid);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL abort_ptr: got %b expected 0100", gnt);
    end
  endtask

  task automatic test_reset_mid_burst;
    int bad;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, data_out, data_valid, warmup_done} !== 14'b0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b data=%h valid=%b wd=%b expected all 0",
               gnt, data_out, data_valid, warmup_done);
    end
    #2 rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (warmup_done !== 1'b0 || gnt !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rewarm_quiet: got %0d active cycles expected 0", bad);
    end
    tick();
    checks++;
    if (warmup_done !== 1'b1) begin
      errors++;
      $display("FAIL rewarm_done: got %b expected 1", warmup_done);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL rewarm_grant: got gnt=%b valid=%b expected 0001 1", gnt, data_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_warmup();
    test_burst_content();
    test_fairness();
    test_stall();
    test_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_rng_arbiter.md
# lfsr_rng_arbiter

Shares the free-running 8-bit random byte stream from the LFSR generator among `NREQ` requesters. After reset, it discards a programmable warm-up window. It then grants the stream round-robin, one requester at a time, as bursts of `BURST` bytes over a valid/ready handshake. It sits between the generator's `random` output and the consumers of random bytes, such as test-pattern, scrambler and jitter blocks.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `BURST`, 4: bytes delivered per grant (1..16).
- `WARMUP_CYCLES`, 64: generator outputs discarded after reset (1..255).

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `rnd_in`, in, 8: generator output; a new byte every cycle.
- `req`, in, NREQ: level request per requester; held until the burst completes.
- `data_ready`, in, NREQ: per-requester ready; only the granted bit is used.
- `gnt`, out, NREQ: one-hot registered grant; all-zero when idle.
- `data_out`, out, 8: registered random byte.
- `data_valid`, out, 1: `data_out` is valid for the granted requester.
- `warmup_done`, out, 1: high once warm-up completes; stays high until reset.

## Operation
- Reset values: `gnt`=0, `data_out`=0, `data_valid`=0, `warmup_done`=0; state WARMUP, warm-up counter 0, beat counter 0, round-robin pointer 0.
- WARMUP:
  - Counter increments every cycle.
  - When it reaches `WARMUP_CYCLES-1`, `warmup_done` goes high and the FSM moves to IDLE.
  - `req` is ignored in this state.
- IDLE:
  - If any `req` bit is set, select the first set bit at or after the pointer, wrapping modulo `NREQ`.
  - Register `gnt` one-hot, load `data_out<=rnd_in`, set `data_valid`=1, clear the beat counter, and go to BURST.
  - Pointer becomes (winner+1) mod `NREQ`.
- BURST:
  - A beat is accepted when `data_valid & data_ready[granted]`.
  - On accept, not last beat: `data_out<=rnd_in`, beat counter +1.
  - On accept of the last beat (counter = `BURST-1`): `gnt`=0, `data_valid`=0, go to IDLE.
  - Stall (`data_ready` low): `data_out` holds. Generator bytes produced during the stall are discarded, never queued.
  - Abort: if `req[granted]` drops in BURST, the next cycle gives `gnt`=0, `data_valid`=0, IDLE. A beat accepted in that same cycle still counts as delivered.
- Each `rnd_in` byte is delivered to at most one requester, at most once.
- `req` bits of non-granted requesters have no effect until IDLE.
- Widths:
  - Beat counter is `$clog2(BURST)` bits, minimum 1.
  - Warm-up counter is 8 bits.
  - Pointer is `$clog2(NREQ)` bits, minimum 1; wrap from `NREQ-1` to 0 is explicit, since `NREQ` need not be a power of 2.

## Timing
- Arbitration latency: `req` sampled high in IDLE gives `gnt` and `data_valid` the next cycle.
- Throughput: 1 byte/cycle with `data_ready` held high. A burst takes `BURST` cycles.
- Burst spacing: IDLE lasts at least one cycle between bursts, so back-to-back grants are `BURST+1` cycles apart.
- First possible grant: cycle `WARMUP_CYCLES+1` after reset release.
- Reset mid-burst: asynchronous. Outputs clear immediately and warm-up restarts.
- Simultaneous requests: only the pointer decides; there is no fixed priority.
- Last-beat accept coinciding with a `req` drop is a normal completion; the result is identical.

## Structure
- Shared package `lfsr_pkg`:
  - FSM state enum `{WARMUP, IDLE, BURST}`.
  - Byte width constant `RND_W=8`.
- Sub-module `rr_pick`:
  - Combinational round-robin selector.
  - Inputs: request vector and pointer. Outputs: one-hot winner, winner index, `any`.
  - Reused later for other shared-resource arbiters.

## Test plan
- Warm-up: `WARMUP_CYCLES`=64, `req`=4'b0001 held from reset → `warmup_done` rises at cycle 64; `gnt`=4'b0001 at cycle 65; no `data_valid` before then.
- Burst content: `rnd_in` ramps 0x10,0x11,…, `data_ready`=1, `BURST`=4 → `data_out` = 4 consecutive `rnd_in` values, each 1 cycle later; `gnt` clears after the 4th beat.
- Fairness: `req`=4'b1111 continuously → grant order 0,1,2,3,0; bursts spaced 5 cycles apart.
- Stall: `data_ready` low for 3 cycles on beat 2 → `data_out` holds; the next byte equals `rnd_in` at the accept cycle; skipped bytes never appear.
- Abort: `req[1]` drops after beat 1 → next cycle `gnt`=0, `data_valid`=0; the pointer has already moved to 2.
- Reset mid-burst: `rst_n` low during beat 2 → all outputs 0 asynchronously; full 64-cycle warm-up repeats.
